// File: rtl/resized_crop_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// resized_crop_core : runtime crop window + nearest-neighbour resize of a
// multi-plane BRAM image, streamed out over valid/ready.   Rev 1.0
// ----------------------------------------------------------------------------
module resized_crop_core #(
  parameter int IN_W     = 28,
  parameter int IN_H     = 28,
  parameter int OUT_W    = 28,
  parameter int OUT_H    = 28,
  parameter int CHANNELS = 1,
  parameter int PIX_W    = 8,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      crop_x,
  input  logic [15:0]      crop_y,
  input  logic [15:0]      crop_w,
  input  logic [15:0]      crop_h,
  output logic [31:0]      bram_address,
  input  logic [31:0]      bram_data,
  output logic [PIX_W-1:0] pixel_o,
  output logic             pixel_valid,
  input  logic             pixel_ready,
  output logic             busy,
  output logic             image_done,
  output logic             crop_err
);
  localparam int PPW    = 32 / PIX_W;
  localparam int LANE_W = $clog2(PPW);
  localparam int DEPTH  = READ_LAT + 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [31:0] PLANE_PIX = 32'(IN_W * IN_H);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SETUP = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic [15:0] cx_q, cx_d, cy_q, cy_d, cw_q, cw_d, ch_q, ch_d;
  logic [15:0] qw_q, qw_d, rw_q, rw_d, qh_q, qh_d, rh_q, rh_d;
  logic [15:0] ox_q, ox_d, oy_q, oy_d, chn_q, chn_d;
  logic [15:0] xq_q, xq_d, xr_q, xr_d, yq_q, yq_d, yr_q, yr_d;
  logic [31:0] plane_q, plane_d;
  logic [CNT_W-1:0] credit_q, credit_d, cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [READ_LAT-1:0] sr_vld_q, sr_vld_d;
  logic [READ_LAT-1:0][LANE_W-1:0] sr_lane_q, sr_lane_d;
  logic [DEPTH-1:0][PIX_W-1:0] fifo_q, fifo_d;

  logic [31:0] pix_idx;
  logic [16:0] x_sum, y_sum;
  logic        issue, pop, push, win_bad;

  assign pix_idx      = plane_q + (32'(cy_q) + 32'(yq_q)) * 32'(IN_W) + 32'(cx_q) + 32'(xq_q);
  assign bram_address = pix_idx >> LANE_W;
  assign x_sum        = {1'b0, xr_q} + {1'b0, rw_q};
  assign y_sum        = {1'b0, yr_q} + {1'b0, rh_q};
  assign pixel_valid  = (cnt_q != '0);
  assign pixel_o      = pixel_valid ? fifo_q[rd_q] : '0;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign pop          = pixel_valid && pixel_ready;
  assign push         = sr_vld_q[READ_LAT-1];
  assign win_bad      = (cw_q == 16'd0) || (ch_q == 16'd0) ||
                        (({1'b0, cx_q} + {1'b0, cw_q}) > 17'(IN_W)) ||
                        (({1'b0, cy_q} + {1'b0, ch_q}) > 17'(IN_H));

  always_comb begin
    state_d = state_q;
    cx_d = cx_q; cy_d = cy_q; cw_d = cw_q; ch_d = ch_q;
    qw_d = qw_q; rw_d = rw_q; qh_d = qh_q; rh_d = rh_q;
    ox_d = ox_q; oy_d = oy_q; chn_d = chn_q;
    xq_d = xq_q; xr_d = xr_q; yq_d = yq_q; yr_d = yr_q;
    plane_d    = plane_q;
    issue      = 1'b0;
    crop_err   = 1'b0;
    image_done = 1'b0;

    case (state_q)
      S_IDLE: if (start) begin
        cx_d = crop_x; cy_d = crop_y; cw_d = crop_w; ch_d = crop_h;
        state_d = S_CHECK;
      end
      S_CHECK: if (win_bad) begin
        crop_err = 1'b1;
        state_d  = S_IDLE;
      end else begin
        qw_d = '0; rw_d = cw_q; qh_d = '0; rh_d = ch_q;
        ox_d = '0; oy_d = '0; chn_d = '0; plane_d = '0;
        xq_d = '0; xr_d = '0; yq_d = '0; yr_d = '0;
        state_d = S_SETUP;
      end
      // Both divisions run side by side, one subtraction per dimension per cycle.
      S_SETUP: begin
        if (rw_q >= 16'(OUT_W)) begin rw_d = rw_q - 16'(OUT_W); qw_d = qw_q + 16'd1; end
        if (rh_q >= 16'(OUT_H)) begin rh_d = rh_q - 16'(OUT_H); qh_d = qh_q + 16'd1; end
        if ((rw_q < 16'(OUT_W)) && (rh_q < 16'(OUT_H))) state_d = S_RUN;
      end
      S_RUN: begin
        // A pop in this cycle frees a slot in time to keep one issue per cycle.
        issue = (credit_q != '0) || pop;
        if (issue) begin
          if (ox_q == 16'(OUT_W - 1)) begin
            ox_d = '0; xq_d = '0; xr_d = '0;
            if (oy_q == 16'(OUT_H - 1)) begin
              oy_d = '0; yq_d = '0; yr_d = '0;
              chn_d   = chn_q + 16'd1;
              plane_d = plane_q + PLANE_PIX;
              if (chn_q == 16'(CHANNELS - 1)) state_d = S_DRAIN;
            end else begin
              oy_d = oy_q + 16'd1;
              if (y_sum >= 17'(OUT_H)) begin
                yr_d = 16'(y_sum - 17'(OUT_H)); yq_d = yq_q + qh_q + 16'd1;
              end else begin
                yr_d = y_sum[15:0]; yq_d = yq_q + qh_q;
              end
            end
          end else begin
            ox_d = ox_q + 16'd1;
            if (x_sum >= 17'(OUT_W)) begin
              xr_d = 16'(x_sum - 17'(OUT_W)); xq_d = xq_q + qw_q + 16'd1;
            end else begin
              xr_d = x_sum[15:0]; xq_d = xq_q + qw_q;
            end
          end
        end
      end
      S_DRAIN: if (pop && (cnt_q == CNT_W'(1)) && (sr_vld_q == '0)) state_d = S_DONE;
      S_DONE: begin
        image_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = READ_LAT - 1; i > 0; i--) begin
      sr_vld_d[i]  = sr_vld_q[i-1];
      sr_lane_d[i] = sr_lane_q[i-1];
    end
    sr_vld_d[0]  = issue;
    sr_lane_d[0] = pix_idx[LANE_W-1:0];

    fifo_d   = fifo_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    credit_d = credit_q - CNT_W'(issue) + CNT_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      fifo_d[wr_q] = PIX_W'(bram_data >> (32'(sr_lane_q[READ_LAT-1]) * 32'(PIX_W)));
      wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
    end
    if (pop) rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);

    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      crop_err   = 1'b0;
      image_done = 1'b0;
      credit_d   = CNT_W'(DEPTH);
      cnt_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
      sr_vld_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cx_q <= '0; cy_q <= '0; cw_q <= '0; ch_q <= '0;
      qw_q <= '0; rw_q <= '0; qh_q <= '0; rh_q <= '0;
      ox_q <= '0; oy_q <= '0; chn_q <= '0;
      xq_q <= '0; xr_q <= '0; yq_q <= '0; yr_q <= '0;
      plane_q   <= '0;
      credit_q  <= CNT_W'(DEPTH);
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      sr_vld_q  <= '0;
      sr_lane_q <= '0;
      fifo_q    <= '0;
    end else begin
      state_q <= state_d;
      cx_q <= cx_d; cy_q <= cy_d; cw_q <= cw_d; ch_q <= ch_d;
      qw_q <= qw_d; rw_q <= rw_d; qh_q <= qh_d; rh_q <= rh_d;
      ox_q <= ox_d; oy_q <= oy_d; chn_q <= chn_d;
      xq_q <= xq_d; xr_q <= xr_d; yq_q <= yq_d; yr_q <= yr_d;
      plane_q   <= plane_d;
      credit_q  <= credit_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      sr_vld_q  <= sr_vld_d;
      sr_lane_q <= sr_lane_d;
      fifo_q    <= fifo_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_resized_crop_core.sv
`default_nettype none
// tb_resized_crop_core: two configurations share one stimulus stream; each has its
// own BRAM model and a scoreboard filled from a direct-division reference.
module tb_resized_crop_core;
  logic        clk = 1'b0;
  logic        reset, start, abort, pixel_ready;
  logic [15:0] crop_x, crop_y, crop_w, crop_h;

  // A: 8x8 in, 4x4 out, 8-bit, 1 plane, latency 1
  logic [31:0] addr_a, data_a;
  logic [7:0]  pix_a;
  logic        pv_a, busy_a, done_a_s, err_a_s;
  // B: 4x4 in, 4x4 out, 16-bit, 2 planes, latency 2
  logic [31:0] addr_b, data_b, data_b1;
  logic [15:0] pix_b;
  logic        pv_b, busy_b, done_b_s, err_b_s;

  int n_checks = 0, n_fail = 0, cyc = 0;
  int qa[$], qb[$];
  int hs_a = 0, hs_b = 0, first_a = 0, first_b = 0, last_a = 0, last_b = 0;
  int dones_a = 0, dones_b = 0, errs_a = 0, errs_b = 0;
  bit stall_a = 1'b0, stall_b = 1'b0, rnd_ready = 1'b0;
  logic [15:0] held_a = '0, held_b = '0;

  resized_crop_core #(.IN_W(8), .IN_H(8), .OUT_W(4), .OUT_H(4), .CHANNELS(1),
                      .PIX_W(8), .READ_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .crop_x(crop_x), .crop_y(crop_y), .crop_w(crop_w), .crop_h(crop_h),
    .bram_address(addr_a), .bram_data(data_a), .pixel_o(pix_a), .pixel_valid(pv_a),
    .pixel_ready(pixel_ready), .busy(busy_a), .image_done(done_a_s), .crop_err(err_a_s));

  resized_crop_core #(.IN_W(4), .IN_H(4), .OUT_W(4), .OUT_H(4), .CHANNELS(2),
                      .PIX_W(16), .READ_LAT(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .crop_x(crop_x), .crop_y(crop_y), .crop_w(crop_w), .crop_h(crop_h),
    .bram_address(addr_b), .bram_data(data_b), .pixel_o(pix_b), .pixel_valid(pv_b),
    .pixel_ready(pixel_ready), .busy(busy_b), .image_done(done_b_s), .crop_err(err_b_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_a(input logic [31:0] w);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[l*8 +: 8] = 8'((4 * w + l) & 255);
    return r;
  endfunction

  function automatic logic [31:0] word_b(input logic [31:0] w);
    logic [31:0] r;
    int pi;
    for (int l = 0; l < 2; l++) begin
      pi = 2 * int'(w) + l;
      r[l*16 +: 16] = 16'((pi % 16) + 100 * (pi / 16));
    end
    return r;
  endfunction

  always @(posedge clk) begin
    data_a  <= word_a(addr_a);
    data_b1 <= word_b(addr_b);
    data_b  <= data_b1;
  end

  always @(posedge clk) begin
    #1;
    pixel_ready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (reset) begin
    if (pv_a && pixel_ready) begin
      if (qa.size() == 0) check_val("A_extra_pixel", 1, 0);
      else check_val("A_pixel", 32'(pix_a), qa.pop_front());
      if (hs_a == 0) first_a = cyc;
      last_a = cyc;
      hs_a++;
    end
    if (stall_a) begin
      check_val("A_hold_valid", 32'(pv_a), 1);
      check_val("A_hold_data", 32'(pix_a), 32'(held_a));
    end
    stall_a = pv_a && !pixel_ready && !abort;
    held_a  = 16'(pix_a);
    if (done_a_s) begin
      dones_a++;
      check_val("A_done_latency", cyc, last_a + 1);
      check_val("A_busy_at_done", 32'(busy_a), 0);
    end
    if (err_a_s) begin
      errs_a++;
      check_val("A_valid_at_err", 32'(pv_a), 0);
    end
  end

  always @(negedge clk) if (reset) begin
    if (pv_b && pixel_ready) begin
      if (qb.size() == 0) check_val("B_extra_pixel", 1, 0);
      else check_val("B_pixel", 32'(pix_b), qb.pop_front());
      if (hs_b == 0) first_b = cyc;
      last_b = cyc;
      hs_b++;
    end
    if (stall_b) begin
      check_val("B_hold_valid", 32'(pv_b), 1);
      check_val("B_hold_data", 32'(pix_b), 32'(held_b));
    end
    stall_b = pv_b && !pixel_ready && !abort;
    held_b  = pix_b;
    if (done_b_s) begin
      dones_b++;
      check_val("B_done_latency", cyc, last_b + 1);
      check_val("B_busy_at_done", 32'(busy_b), 0);
    end
    if (err_b_s) begin
      errs_b++;
      check_val("B_valid_at_err", 32'(pv_b), 0);
    end
  end

  task automatic load_expect(input int cx, input int cy, input int cw, input int ch,
                             output bit va, output bit vb);
    va = (cw != 0) && (ch != 0) && (cx + cw <= 8) && (cy + ch <= 8);
    vb = (cw != 0) && (ch != 0) && (cx + cw <= 4) && (cy + ch <= 4);
    if (va)
      for (int oy = 0; oy < 4; oy++)
        for (int ox = 0; ox < 4; ox++)
          qa.push_back(((cy + (oy * ch) / 4) * 8 + cx + (ox * cw) / 4) & 255);
    if (vb)
      for (int c = 0; c < 2; c++)
        for (int oy = 0; oy < 4; oy++)
          for (int ox = 0; ox < 4; ox++)
            qb.push_back((cy + (oy * ch) / 4) * 4 + cx + (ox * cw) / 4 + 100 * c);
  endtask

  task automatic pulse_start(input int cx, input int cy, input int cw, input int ch,
                             input bit with_abort);
    crop_x = 16'(cx); crop_y = 16'(cy); crop_w = 16'(cw); crop_h = 16'(ch);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_image(input int cx, input int cy, input int cw, input int ch,
                           input bit rnd, input bit with_abort);
    bit va, vb;
    int n, d0a, d0b, e0a, e0b;
    load_expect(cx, cy, cw, ch, va, vb);
    rnd_ready = rnd;
    hs_a = 0; hs_b = 0;
    d0a = dones_a; d0b = dones_b; e0a = errs_a; e0b = errs_b;
    pulse_start(cx, cy, cw, ch, with_abort);
    n = 0;
    while ((busy_a || busy_b) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("run_timeout", 32'(n < 4000), 1);
    check_val("A_left_in_queue", qa.size(), 0);
    check_val("B_left_in_queue", qb.size(), 0);
    check_val("A_done_count", dones_a - d0a, 32'(va));
    check_val("B_done_count", dones_b - d0b, 32'(vb));
    check_val("A_err_count", errs_a - e0a, 32'(!va));
    check_val("B_err_count", errs_b - e0b, 32'(!vb));
    if (va && !rnd) check_val("A_no_bubbles", last_a - first_a + 1, 16);
    if (vb && !rnd) check_val("B_no_bubbles", last_b - first_b + 1, 32);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    bit va, vb;
    int n, d0a, d0b, e0a, e0b;
    reset = 1'b0; start = 1'b0; abort = 1'b0; pixel_ready = 1'b1;
    crop_x = '0; crop_y = '0; crop_w = '0; crop_h = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_addr_a", addr_a, 0);
    check_val("rst_addr_b", addr_b, 0);
    check_val("rst_pix_a", 32'(pix_a), 0);
    check_val("rst_pix_b", 32'(pix_b), 0);
    check_val("rst_valid", 32'({pv_a, pv_b}), 0);
    check_val("rst_busy", 32'({busy_a, busy_b}), 0);
    check_val("rst_pulses", 32'({done_a_s, done_b_s, err_a_s, err_b_s}), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_image(0, 0, 4, 4, 1'b0, 1'b0);   // identity / plane offset
    run_image(0, 0, 8, 8, 1'b0, 1'b0);   // downscale on A, rejected on B
    run_image(1, 1, 2, 2, 1'b0, 1'b0);   // upscale with offset
    run_image(0, 0, 4, 4, 1'b1, 1'b0);   // random backpressure
    run_image(4, 4, 4, 4, 1'b1, 1'b0);   // window on A's far edge, rejected on B
    run_image(7, 0, 2, 4, 1'b0, 1'b0);   // out of bounds on both
    run_image(0, 0, 4, 0, 1'b0, 1'b0);   // zero height
    run_image(3, 0, 1, 4, 1'b0, 1'b0);   // single-column upscale

    // abort after 5 accepted pixels
    load_expect(0, 0, 4, 4, va, vb);
    rnd_ready = 1'b0;
    hs_a = 0; hs_b = 0;
    d0a = dones_a; d0b = dones_b; e0a = errs_a; e0b = errs_b;
    pulse_start(0, 0, 4, 4, 1'b0);
    n = 0;
    while (hs_a < 5 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("abort_reach_5", 32'(n < 200), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_val("abort_busy_a", 32'(busy_a), 0);
    check_val("abort_busy_b", 32'(busy_b), 0);
    check_val("abort_valid_a", 32'(pv_a), 0);
    check_val("abort_valid_b", 32'(pv_b), 0);
    repeat (10) @(posedge clk);
    #1;
    check_val("abort_no_done", (dones_a - d0a) + (dones_b - d0b), 0);
    check_val("abort_no_err", (errs_a - e0a) + (errs_b - e0b), 0);
    qa.delete();
    qb.delete();

    run_image(0, 0, 4, 4, 1'b1, 1'b1);   // start with coincident abort in IDLE
    run_image(1, 1, 2, 2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
